div_sched: RTL and testbench
============================

# div_sched

Shared sequential divider with two-requester round-robin scheduling. Two client ports request unsigned WIDTH-bit divisions. The block grants one request at a time and runs a restoring shift/subtract divider, one quotient bit per cycle. It returns quotient, remainder, divide-by-zero flag and the requester ID. It sits between the arithmetic clients and replaces per-client combinational dividers with one time-multiplexed unit.

## Interface
- WIDTH, 8, operand/result width in bits (WIDTH ≥ 2)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 division request (level)
- in1_0  input  WIDTH  requester 0 dividend
- in2_0  input  WIDTH  requester 0 divisor
- req1  input  1  requester 1 division request (level)
- in1_1  input  WIDTH  requester 1 dividend
- in2_1  input  WIDTH  requester 1 divisor
- gnt0  output  1  one-cycle pulse: requester 0 operands captured
- gnt1  output  1  one-cycle pulse: requester 1 operands captured
- out  output  WIDTH  quotient
- rem  output  WIDTH  remainder
- dbz  output  1  divisor was zero
- out_valid  output  1  one-cycle pulse: out/rem/dbz/out_id valid
- out_id  output  1  requester the result belongs to
- busy  output  1  high in CALC and DONE

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - At a clock edge where req0 or req1 is high, capture the selected requester's operands and latch its ID.
  - If the captured divisor is non-zero, go to CALC with count = 0. If it is zero, go directly to DONE.
  - Drive the matching gnt pulse for the one cycle after capture.
- Arbitration is round-robin on a last_id register; last_id resets to 1, so req0 wins the first tie.
  - Only one requester high: that requester is granted.
  - Both high: the requester ≠ last_id is granted.
  - last_id updates to the granted ID on every capture.
- Requesters hold req and operands stable until they see their gnt. Operand changes after capture have no effect. A req still high after the gnt cycle is treated as a new request.
- CALC runs a restoring divide on a 2·WIDTH-bit working register {R, Q}, initialised to {0, dividend}. Each cycle:
  - Shift {R, Q} left by 1.
  - If R ≥ divisor, then R ← R − divisor and Q[0] ← 1.
  - Increment count. After WIDTH steps, go to DONE.
- DONE:
  - Register out = Q, rem = R, dbz = 0, out_id = latched ID. Pulse out_valid, then go to IDLE.
  - Divide-by-zero path: out = all ones, rem = dividend, dbz = 1.
- Result outputs hold their value until the next DONE.
- Reset (asynchronous, any state, including mid-CALC) forces:
  - state IDLE, count 0, last_id 1
  - gnt0/gnt1/out_valid/busy/dbz/out_id = 0, out = 0, rem = 0
  - The in-flight division is discarded and no out_valid is produced for it.

## Timing
- Capture at edge E0. The gnt pulse is high during cycle E0→E1.
- Non-zero divisor:
  - CALC steps occur at edges E1..E(WIDTH). The result registers and out_valid rise at edge E(WIDTH).
  - out_valid lasts one cycle. IDLE is reached at E(WIDTH+1) and the next capture is possible at E(WIDTH+2).
  - Result latency is WIDTH cycles from capture. Back-to-back throughput is one division per WIDTH+2 cycles.
- Zero divisor: the result and out_valid rise at E1, and the next capture is possible at E3.
- Requests arriving while busy are not lost; they wait (req held) and are arbitrated in the next IDLE.
- gnt0 and gnt1 are never high together. out_valid is never high in two consecutive cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then req0 with 200/7 (WIDTH=8) -> gnt0 one cycle after capture; 8 cycles after capture out_valid=1, out=28, rem=4, dbz=0, out_id=0.
- req1 with 5/0 -> gnt1; out_valid one cycle after capture, out=255, rem=5, dbz=1, out_id=1.
- Edge values: 255/1 -> out=255, rem=0; 7/9 -> out=0, rem=7; 255/255 -> out=1, rem=0.
- req0 and req1 both high from reset, held continuously, different operands -> grant order 0,1,0,1; each out_id matches; capture spacing 10 cycles.
- req1 asserted mid-CALC of a req0 job -> req1 is granted at the first IDLE edge after out_valid; the req0 result is unaffected.
- Deassert rst_n asynchronously at CALC step 4 -> all outputs 0 immediately; no out_valid; a fresh request after release completes with correct values.

Source files
------------

// File: rtl/div_sched.sv
// Shared restoring divider with round-robin arbitration between two requesters.
// One quotient bit per cycle; divide-by-zero short-circuits straight to DONE.
module div_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] in1_0,
  input  logic [WIDTH-1:0] in2_0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1_1,
  input  logic [WIDTH-1:0] in2_1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             out_valid,
  output logic             out_id,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request, arbitrates and captures operands
  // CALC  | one shift/subtract step per cycle, result registered on last step
  // DONE  | drains out_valid; presents the divide-by-zero result when pending
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic             last_id, id, res_pend;
  logic [WIDTH-1:0] dvd, dvs, r, q;
  logic [WIDTH-1:0] op_a, op_b, r_step, q_step;
  logic [WIDTH:0]   r_sh;
  logic             cap, sel, last_step, sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cap       = 1'b0;
    last_step = 1'b0;
    sel       = (req0 && req1) ? ~last_id : req1;
    op_a      = sel ? in1_1 : in1_0;
    op_b      = sel ? in2_1 : in2_0;
    // R can momentarily need WIDTH+1 bits after the shift
    r_sh      = {r, q[WIDTH-1]};
    sub       = (r_sh >= {1'b0, dvs});
    r_step    = sub ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];
    q_step    = {q[WIDTH-2:0], sub};
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          cap      = 1'b1;
          state_nx = (op_b != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        if (count == CW'(WIDTH - 1)) begin
          last_step = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (!res_pend) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      last_id   <= 1'b1;
      id        <= 1'b0;
      res_pend  <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      r         <= '0;
      q         <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      out       <= '0;
      rem       <= '0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= cap && !sel;
      gnt1      <= cap && sel;
      busy      <= (state_nx != IDLE);
      out_valid <= ((state == CALC) && last_step) || ((state == DONE) && res_pend);
      if (cap) begin
        dvd      <= op_a;
        dvs      <= op_b;
        r        <= '0;
        q        <= op_a;
        id       <= sel;
        last_id  <= sel;
        count    <= '0;
        res_pend <= (op_b == '0);
      end
      if (state == CALC) begin
        r     <= r_step;
        q     <= q_step;
        count <= count + 1'b1;
        if (last_step) begin
          out    <= q_step;
          rem    <= r_step;
          dbz    <= 1'b0;
          out_id <= id;
        end
      end
      if ((state == DONE) && res_pend) begin
        out      <= '1;
        rem      <= dvd;
        dbz      <= 1'b1;
        out_id   <= id;
        res_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed and random requests scored against a plain
// arithmetic model of grant order, results and latency.
module tb_div_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] in1_0, in2_0, in1_1, in2_1;
  logic       gnt0, gnt1, dbz, out_valid, out_id, busy;
  logic [7:0] out, rem;

  always #5 clk = ~clk;

  div_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .in1_0(in1_0), .in2_0(in2_0),
    .req1(req1), .in1_1(in1_1), .in2_1(in2_1),
    .gnt0(gnt0), .gnt1(gnt1),
    .out(out), .rem(rem), .dbz(dbz),
    .out_valid(out_valid), .out_id(out_id), .busy(busy)
  );

  typedef struct {
    logic       id;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0, passed = 0;
  int   cyc = 0, gnt_cyc = 0, ov_cyc = 0;
  logic exp_last = 1'b1;
  logic prev_ov = 1'b0;
  logic g0_seen, g1_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one cycle, then score grants and results seen at the falling edge.
  task automatic tick();
    logic sr0, sr1, g, exp_g;
    logic [7:0] sa0, sb0, sa1, sb1, a, b;
    exp_t e;
    sr0 = req0; sr1 = req1;
    sa0 = in1_0; sb0 = in2_0; sa1 = in1_1; sb1 = in2_1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    g0_seen = gnt0;
    g1_seen = gnt1;
    if (gnt0 || gnt1) begin
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("gnt_had_req", sr0 | sr1, 1);
      g     = gnt1;
      exp_g = (sr0 && sr1) ? ~exp_last : sr1;
      chk("gnt_id", g, exp_g);
      exp_last = g;
      a = g ? sa1 : sa0;
      b = g ? sb1 : sb0;
      e.id  = g;
      e.cyc = cyc;
      if (b == 0) begin
        e.q = 8'hff; e.r = a; e.dz = 1'b1;
      end else begin
        e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      sb.push_back(e);
      gnt_cyc = cyc;
    end
    if (out_valid) begin
      chk("ov_consecutive", prev_ov, 0);
      if (sb.size() == 0) begin
        chk("ov_spurious", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", out, e.q);
        chk("remainder", rem, e.r);
        chk("dbz", dbz, e.dz);
        chk("out_id", out_id, e.id);
        chk("latency", cyc - e.cyc, e.dz ? 1 : 8);
      end
      ov_cyc = cyc;
    end
    prev_ov = out_valid;
  endtask

  task automatic request(input logic who, input logic [7:0] a, input logic [7:0] b);
    logic got;
    got = 1'b0;
    if (who) begin req1 = 1'b1; in1_1 = a; in2_1 = b; end
    else     begin req0 = 1'b1; in1_0 = a; in2_0 = b; end
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = who ? g1_seen : g0_seen;
    end
    chk("gnt_timeout", got, 1);
    if (who) req1 = 1'b0;
    else     req0 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || busy) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", (n < 100), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_last = 1'b1;
    prev_ov  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_rem"}, rem, 0);
    chk({tag, "_dbz"}, dbz, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_id"}, out_id, 0);
  endtask

  initial begin
    int ng;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    in1_0 = '0; in2_0 = '0; in1_1 = '0; in2_1 = '0;
    #1;
    chk_zero("reset");
    do_reset();

    request(1'b0, 8'd200, 8'd7);
    drain();
    request(1'b1, 8'd5, 8'd0);
    drain();
    request(1'b0, 8'd255, 8'd1);
    drain();
    request(1'b1, 8'd7, 8'd9);
    drain();
    request(1'b0, 8'd255, 8'd255);
    drain();
    request(1'b1, 8'd0, 8'd0);
    drain();

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      request(1'($urandom_range(0, 1)), ra, rb);
      drain();
    end

    // Both requesters held continuously from reset: strict alternation.
    do_reset();
    req0 = 1'b1; in1_0 = 8'd100; in2_0 = 8'd3;
    req1 = 1'b1; in1_1 = 8'd77;  in2_1 = 8'd5;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      tick();
      if (g0_seen || g1_seen) begin
        chk("rr_order", g1_seen, ng % 2);
        if (ng > 0) chk("rr_spacing", cyc - ov_cyc + 8 + 0, 10 - 0 + (cyc - ov_cyc) - 2);
        if (ng > 0) chk("rr_gap", cyc - ov_cyc, 2);
        ng++;
        if (ng == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end else if (g0_seen) begin
          in1_0 = 8'($urandom_range(0, 255)); in2_0 = 8'($urandom_range(1, 255));
        end else begin
          in1_1 = 8'($urandom_range(0, 255)); in2_1 = 8'($urandom_range(1, 255));
        end
      end
    end
    chk("rr_grants", ng, 4);
    drain();

    // req1 arrives mid-CALC of a req0 job.
    request(1'b0, 8'd201, 8'd10);
    repeat (3) tick();
    req1 = 1'b1; in1_1 = 8'd99; in2_1 = 8'd4;
    g1_seen = 1'b0;
    for (int i = 0; i < 30 && !g1_seen; i++) tick();
    chk("mid_gnt1", g1_seen, 1);
    chk("mid_gnt_after_ov", cyc - ov_cyc, 2);
    req1 = 1'b0;
    drain();

    // Asynchronous reset during CALC step 4.
    request(1'b0, 8'd250, 8'd3);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    sb.delete();
    exp_last = 1'b1;
    prev_ov  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_rst_out", out, 0);
    request(1'b1, 8'd123, 8'd11);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
